// File: rtl/channel_error_injector.sv
// Bit-error injection stage of the channel model: inverts each valid bit with
// probability error_threshold/256 from a 16-bit Galois LFSR and keeps flip statistics.
module channel_error_injector #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_WIDTH = 16,
  parameter int          RUN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           error_threshold,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 clear_counts,
  output logic                 out_valid,
  output logic                 out_bit,
  output logic                 out_flipped,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [RUN_WIDTH-1:0] max_run
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Stream handshake: valid-only. A bit is transferred on every edge where
  // in_valid=1; there is no ready and no backpressure. out_valid follows one cycle later.

  logic [15:0]          lfsr_q, lfsr_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_bit_q, out_bit_d;
  logic                 out_flipped_q, out_flipped_d;
  logic [CNT_WIDTH-1:0] bit_count_q, bit_count_d;
  logic [CNT_WIDTH-1:0] error_count_q, error_count_d;
  logic [RUN_WIDTH-1:0] run_q, run_d;
  logic [RUN_WIDTH-1:0] max_run_q, max_run_d;

  logic [7:0] rnd;
  logic       flip;

  always_comb begin
    rnd  = lfsr_q[7:0];
    flip = in_valid && (rnd < error_threshold);

    // LFSR holds during gaps so the flip pattern depends only on bit index.
    lfsr_d = lfsr_q;
    if (in_valid) begin
      if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ LFSR_MASK;
      else           lfsr_d = lfsr_q >> 1;
    end

    out_valid_d   = in_valid;
    out_bit_d     = in_valid & (in_bit ^ flip);
    out_flipped_d = flip;

    bit_count_d   = bit_count_q;
    error_count_d = error_count_q;
    run_d         = run_q;
    max_run_d     = max_run_q;

    if (clear_counts) begin
      bit_count_d   = '0;
      error_count_d = '0;
      run_d         = '0;
      max_run_d     = '0;
    end else if (in_valid) begin
      if (bit_count_q != {CNT_WIDTH{1'b1}}) bit_count_d = bit_count_q + CNT_WIDTH'(1);
      if (flip) begin
        if (error_count_q != {CNT_WIDTH{1'b1}}) error_count_d = error_count_q + CNT_WIDTH'(1);
        if (run_q != {RUN_WIDTH{1'b1}})         run_d = run_q + RUN_WIDTH'(1);
      end else begin
        run_d = '0;
      end
      // Max tracks the run value including this bit.
      if (run_d > max_run_q) max_run_d = run_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q        <= SEED_EFF;
      out_valid_q   <= 1'b0;
      out_bit_q     <= 1'b0;
      out_flipped_q <= 1'b0;
      bit_count_q   <= '0;
      error_count_q <= '0;
      run_q         <= '0;
      max_run_q     <= '0;
    end else begin
      lfsr_q        <= lfsr_d;
      out_valid_q   <= out_valid_d;
      out_bit_q     <= out_bit_d;
      out_flipped_q <= out_flipped_d;
      bit_count_q   <= bit_count_d;
      error_count_q <= error_count_d;
      run_q         <= run_d;
      max_run_q     <= max_run_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_bit     = out_bit_q;
  assign out_flipped = out_flipped_q;
  assign bit_count   = bit_count_q;
  assign error_count = error_count_q;
  assign max_run     = max_run_q;

endmodule

// File: tb/tb_channel_error_injector.sv
// Self-checking bench for channel_error_injector: reference model feeds an expected
// queue per driven cycle; a negedge monitor pops and compares DUT outputs.
module tb_channel_error_injector;

  localparam int EW = 54;

  logic       clk;
  logic       reset;
  logic [7:0] error_threshold;
  logic       in_valid;
  logic       in_bit;
  logic       clear_counts;

  logic        out_valid, out_bit, out_flipped;
  logic [15:0] bit_count, error_count;
  logic [7:0]  max_run;

  logic        s_out_valid, s_out_bit, s_out_flipped;
  logic [3:0]  s_bit_count, s_error_count;
  logic [2:0]  s_max_run;

  channel_error_injector #(.LFSR_SEED(16'hACE1), .CNT_WIDTH(16), .RUN_WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .error_threshold(error_threshold), .in_valid(in_valid),
    .in_bit(in_bit), .clear_counts(clear_counts), .out_valid(out_valid), .out_bit(out_bit),
    .out_flipped(out_flipped), .bit_count(bit_count), .error_count(error_count), .max_run(max_run)
  );

  channel_error_injector #(.LFSR_SEED(16'hACE1), .CNT_WIDTH(4), .RUN_WIDTH(3)) u_sat (
    .clk(clk), .reset(reset), .error_threshold(error_threshold), .in_valid(in_valid),
    .in_bit(in_bit), .clear_counts(clear_counts), .out_valid(s_out_valid), .out_bit(s_out_bit),
    .out_flipped(s_out_flipped), .bit_count(s_bit_count), .error_count(s_error_count),
    .max_run(s_max_run)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic flip_log[$];
  logic log_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_lfsr;
  int m_bits, m_errs, m_run, m_max;
  int s_bits, s_errs, s_run, s_max;

  function automatic int sat_inc(input int x, input int w);
    return (x == (1 << w) - 1) ? x : x + 1;
  endfunction

  task automatic drive_cycle(input logic rst, input logic v, input logic b,
                             input logic [7:0] thr, input logic clr);
    logic ev, eb, ef;
    logic [7:0] rnd;
    reset = rst; in_valid = v; in_bit = b; error_threshold = thr; clear_counts = clr;
    if (rst) begin
      m_lfsr = 16'hACE1;
      ev = 0; eb = 0; ef = 0;
      m_bits = 0; m_errs = 0; m_run = 0; m_max = 0;
      s_bits = 0; s_errs = 0; s_run = 0; s_max = 0;
    end else begin
      rnd = m_lfsr[7:0];
      ef  = v && (rnd < thr);
      ev  = v;
      eb  = v ? (b ^ ef) : 1'b0;
      if (v) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      if (clr) begin
        m_bits = 0; m_errs = 0; m_run = 0; m_max = 0;
        s_bits = 0; s_errs = 0; s_run = 0; s_max = 0;
      end else if (v) begin
        m_bits = sat_inc(m_bits, 16);
        s_bits = sat_inc(s_bits, 4);
        if (ef) begin
          m_errs = sat_inc(m_errs, 16); m_run = sat_inc(m_run, 8);
          s_errs = sat_inc(s_errs, 4);  s_run = sat_inc(s_run, 3);
        end else begin
          m_run = 0; s_run = 0;
        end
        if (m_run > m_max) m_max = m_run;
        if (s_run > s_max) s_max = s_run;
      end
    end
    @(posedge clk);
    exp_q.push_back({ev, eb, ef, 16'(m_bits), 16'(m_errs), 8'(m_max),
                     4'(s_bits), 4'(s_errs), 3'(s_max)});
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check_eq("out_valid",     32'(out_valid),     32'(e[53]));
      check_eq("out_bit",       32'(out_bit),       32'(e[52]));
      check_eq("out_flipped",   32'(out_flipped),   32'(e[51]));
      check_eq("bit_count",     32'(bit_count),     32'(e[50:35]));
      check_eq("error_count",   32'(error_count),   32'(e[34:19]));
      check_eq("max_run",       32'(max_run),       32'(e[18:11]));
      check_eq("sat_bit_count", 32'(s_bit_count),   32'(e[10:7]));
      check_eq("sat_err_count", 32'(s_error_count), 32'(e[6:3]));
      check_eq("sat_max_run",   32'(s_max_run),     32'(e[2:0]));
      if (log_en && out_valid) flip_log.push_back(out_flipped);
    end
  end

  // ---------------- stimulus ----------------
  logic data_arr[200];
  logic gap_log[$];

  initial begin
    reset = 1; in_valid = 0; in_bit = 0; error_threshold = 0; clear_counts = 0;
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0);
    check_eq("reset_out_valid", 32'(out_valid), 0);
    check_eq("reset_bit_count", 32'(bit_count), 0);

    // First rnd is 8'hE1=225: threshold 226 flips, 225 does not.
    drive_cycle(0, 1, 0, 226, 0);
    check_eq("tp1_out_bit", 32'(out_bit), 1);
    check_eq("tp1_err", 32'(error_count), 1);
    check_eq("tp1_bits", 32'(bit_count), 1);
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 225, 0);
    check_eq("tp2_out_bit", 32'(out_bit), 0);
    check_eq("tp2_err", 32'(error_count), 0);

    // Threshold 0: never flips.
    drive_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) drive_cycle(0, 1, 1'($urandom_range(0, 1)), 0, 0);
    check_eq("thr0_err", 32'(error_count), 0);
    check_eq("thr0_bits", 32'(bit_count), 1000);
    check_eq("thr0_max_run", 32'(max_run), 0);

    // Gapped vs contiguous streams give the same flip sequence.
    for (int i = 0; i < 200; i++) data_arr[i] = 1'($urandom_range(0, 1));
    drive_cycle(1, 0, 0, 0, 0);
    flip_log.delete();
    log_en = 1;
    for (int i = 0; i < 200; i++) begin
      drive_cycle(0, 1, data_arr[i], 128, 0);
      drive_cycle(0, 0, 0, 128, 0);
      drive_cycle(0, 0, 0, 128, 0);
    end
    @(negedge clk); #1;
    gap_log = flip_log;
    flip_log.delete();
    drive_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) drive_cycle(0, 1, data_arr[i], 128, 0);
    drive_cycle(0, 0, 0, 128, 0);
    @(negedge clk); #1;
    log_en = 0;
    check_eq("gap_len", 32'(gap_log.size()), 200);
    check_eq("cont_len", 32'(flip_log.size()), 200);
    for (int i = 0; i < 200 && i < gap_log.size() && i < flip_log.size(); i++)
      check_eq("gap_vs_cont", 32'(gap_log[i]), 32'(flip_log[i]));

    // Saturation on the narrow instance.
    drive_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) drive_cycle(0, 1, 1'($urandom_range(0, 1)), 255, 0);
    check_eq("sat_bits_stick", 32'(s_bit_count), 15);
    check_eq("sat_err_stick", 32'(s_error_count), 15);
    check_eq("sat_max_stick", 32'(s_max_run), 7);

    // Clear together with a valid bit, then mid-stream reset.
    drive_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive_cycle(0, 1, 1, 255, 0);
    drive_cycle(0, 1, 0, 255, 1);
    check_eq("clr_bits", 32'(bit_count), 0);
    check_eq("clr_err", 32'(error_count), 0);
    check_eq("clr_max", 32'(max_run), 0);
    drive_cycle(0, 1, 1, 255, 0);
    drive_cycle(1, 1, 1, 255, 0);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_bit", 32'(out_bit), 0);
    check_eq("rst_err", 32'(error_count), 0);
    drive_cycle(0, 1, 0, 226, 0);
    check_eq("post_rst_flip", 32'(out_flipped), 1);

    // Full-period run at threshold 255; bit 65536 reuses rnd=8'hE1.
    drive_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) drive_cycle(0, 1, 1'($urandom_range(0, 1)), 255, 0);
    check_eq("period_bits", 32'(bit_count), 65535);
    drive_cycle(0, 1, 0, 226, 0);
    check_eq("period_wrap_flip", 32'(out_flipped), 1);
    check_eq("period_bits_sat", 32'(bit_count), 65535);

    drive_cycle(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check_eq("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
